kamacore_wb_arbiter: RTL and testbench

- Shares the single register-file write port between the in-order pipeline writeback (from kamacore_stage_wb) and a multi-cycle result source (divider / long-latency load unit).
- Multi-cycle results are accepted over a valid/ready handshake into a small FIFO. They drain into free write-port slots, meaning cycles with no pipeline write.
- A starvation counter and a full-FIFO condition raise a registered stall request, which freezes the pipeline so buffered results can retire.

---
 rtl/kamacore_wb_arbiter_pkg.sv | 13 +
 rtl/kamacore_wb_fifo.sv | 56 +++++
 rtl/kamacore_wb_arbiter.sv | 114 +++++++++++
 tb/tb_kamacore_wb_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/kamacore_wb_arbiter_pkg.sv
// rtl/kamacore_wb_arbiter_pkg.sv - shared widths and writeback request type for the wb arbiter
package kamacore_wb_arbiter_pkg;

  localparam int CPU_WIDTH      = 32;
  localparam int REG_ADDR_WIDTH = 5;

  typedef struct packed {
    logic                      valid;
    logic [REG_ADDR_WIDTH-1:0] rd_a;
    logic [CPU_WIDTH-1:0]      data;
  } wb_req_t;

endpackage

// File: rtl/kamacore_wb_fifo.sv
// rtl/kamacore_wb_fifo.sv - multi-cycle result FIFO with per-entry destination invalidate
module kamacore_wb_fifo
  import kamacore_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PW    = $clog2(DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  wb_req_t                   push_data,
  input  logic                      pop,
  input  logic                      inv_en,
  input  logic [REG_ADDR_WIDTH-1:0] inv_a,
  output wb_req_t                   head,
  output logic                      full,
  output logic                      empty,
  output logic [PW-1:0]             count
);

  localparam int AW = PW - 1;

  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  wb_req_t       r_mem [DEPTH];

  assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign empty = (r_wptr == r_rptr);
  assign count = r_wptr - r_rptr;
  assign head  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i].valid <= 1'b0;
      end
    end else begin
      // A younger pipeline write to the same register makes these results dead.
      for (int i = 0; i < DEPTH; i++) begin
        if (inv_en && r_mem[i].valid && (r_mem[i].rd_a == inv_a)) begin
          r_mem[i].valid <= 1'b0;
        end
      end
      if (push) begin
        r_mem[r_wptr[AW-1:0]] <= push_data;
        r_wptr                <= r_wptr + 1'b1;
      end
      if (pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/kamacore_wb_arbiter.sv
// rtl/kamacore_wb_arbiter.sv - shares the regfile write port between pipeline writeback and buffered multi-cycle results
module kamacore_wb_arbiter
  import kamacore_wb_arbiter_pkg::*;
#(
  parameter int BUF_DEPTH    = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pipe_we,
  input  logic [REG_ADDR_WIDTH-1:0] pipe_rd_a,
  input  logic [CPU_WIDTH-1:0]      pipe_rd_data,
  input  logic                      mc_valid,
  output logic                      mc_ready,
  input  logic [REG_ADDR_WIDTH-1:0] mc_rd_a,
  input  logic [CPU_WIDTH-1:0]      mc_data,
  output logic                      pipe_stall,
  output logic                      rf_we,
  output logic [REG_ADDR_WIDTH-1:0] rf_a,
  output logic [CPU_WIDTH-1:0]      rf_data
);

  localparam int PW = $clog2(BUF_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic          r_stall;
  logic [SW-1:0] r_starve;

  logic          w_live;
  logic          w_push;
  logic          w_pop;
  logic          w_drain;
  logic          w_full;
  logic          w_empty;
  logic [PW-1:0] w_count;
  logic [PW-1:0] w_count_next;
  logic [SW-1:0] w_starve_next;
  logic          w_stall_next;
  wb_req_t       w_head;
  wb_req_t       w_push_req;
  wb_req_t       w_out;

  assign w_live = pipe_we && (pipe_rd_a != '0) && !r_stall;

  assign mc_ready = rst && !w_full;

  // Results for x0, or already overwritten by the younger pipeline write, are dropped.
  assign w_push  = mc_valid && mc_ready && (mc_rd_a != '0) &&
                   !(w_live && (mc_rd_a == pipe_rd_a));
  assign w_pop   = rst && !w_live && !w_empty;
  assign w_drain = w_pop && w_head.valid;

  assign w_push_req = '{valid: 1'b1, rd_a: mc_rd_a, data: mc_data};

  kamacore_wb_fifo #(
    .DEPTH (BUF_DEPTH),
    .PW    (PW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (w_push_req),
    .pop       (w_pop),
    .inv_en    (w_live),
    .inv_a     (pipe_rd_a),
    .head      (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count)
  );

  always_comb begin
    w_out = '0;
    if (rst) begin
      if (w_live) begin
        w_out = '{valid: 1'b1, rd_a: pipe_rd_a, data: pipe_rd_data};
      end else if (w_drain) begin
        w_out = w_head;
      end
    end
  end

  assign rf_we   = w_out.valid;
  assign rf_a    = w_out.rd_a;
  assign rf_data = w_out.data;

  assign w_count_next = w_count + PW'(w_push) - PW'(w_pop);

  always_comb begin
    w_starve_next = r_starve;
    if (w_drain || (w_count_next == '0)) begin
      w_starve_next = '0;
    end else if (w_live && !w_empty && w_head.valid && (r_starve != SW'(STARVE_LIMIT))) begin
      w_starve_next = r_starve + 1'b1;
    end
  end

  // A stall forces the head to drain next cycle, which in turn clears the starvation count.
  assign w_stall_next = (w_count_next != '0) &&
                        ((w_starve_next == SW'(STARVE_LIMIT)) || (w_count_next == PW'(BUF_DEPTH)));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stall  <= 1'b0;
      r_starve <= '0;
    end else begin
      r_stall  <= w_stall_next;
      r_starve <= w_starve_next;
    end
  end

  assign pipe_stall = r_stall;

endmodule

// File: tb/tb_kamacore_wb_arbiter.sv
// tb/tb_kamacore_wb_arbiter.sv - randomized self-checking bench for kamacore_wb_arbiter
module tb_kamacore_wb_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pipe_we = 1'b0;
  logic [4:0]  pipe_rd_a = '0;
  logic [31:0] pipe_rd_data = '0;
  logic        mc_valid = 1'b0;
  logic        mc_ready;
  logic [4:0]  mc_rd_a = '0;
  logic [31:0] mc_data = '0;
  logic        pipe_stall;
  logic        rf_we;
  logic [4:0]  rf_a;
  logic [31:0] rf_data;

  kamacore_wb_arbiter #(
    .BUF_DEPTH    (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pipe_we      (pipe_we),
    .pipe_rd_a    (pipe_rd_a),
    .pipe_rd_data (pipe_rd_data),
    .mc_valid     (mc_valid),
    .mc_ready     (mc_ready),
    .mc_rd_a      (mc_rd_a),
    .mc_data      (mc_data),
    .pipe_stall   (pipe_stall),
    .rf_we        (rf_we),
    .rf_a         (rf_a),
    .rf_data      (rf_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        v;
    bit [4:0]  rd;
    bit [31:0] data;
  } ent_t;

  ent_t q[$];
  int   m_starve = 0;
  bit   m_stall  = 0;

  int n_checks = 0;
  int n_fail   = 0;

  logic        o_we, o_rdy, o_stall;
  logic [4:0]  o_a;
  logic [31:0] o_d;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input bit rn, input bit we, input bit [4:0] rd, input bit [31:0] d,
                     input bit mv, input bit [4:0] mrd, input bit [31:0] md);
    bit        live, hv, popped, drained, e_we, e_rdy;
    bit [4:0]  e_a;
    bit [31:0] e_d;
    rst = rn; pipe_we = we; pipe_rd_a = rd; pipe_rd_data = d;
    mc_valid = mv; mc_rd_a = mrd; mc_data = md;
    #1;
    live  = rn && we && (rd != 0) && !m_stall;
    hv    = (q.size() > 0) && q[0].v;
    e_rdy = rn && (q.size() < DEPTH);
    e_we = 0; e_a = 0; e_d = 0;
    if (rn) begin
      if (live) begin
        e_we = 1; e_a = rd; e_d = d;
      end else if (hv) begin
        e_we = 1; e_a = q[0].rd; e_d = q[0].data;
      end
    end
    o_we = rf_we; o_a = rf_a; o_d = rf_data; o_rdy = mc_ready; o_stall = pipe_stall;
    chk("rf_we", rf_we, e_we);
    chk("rf_a", rf_a, e_a);
    chk("rf_data", rf_data, e_d);
    chk("mc_ready", mc_ready, e_rdy);
    chk("pipe_stall", pipe_stall, m_stall);
    if (!rn) begin
      q.delete(); m_starve = 0; m_stall = 0;
    end else begin
      popped  = !live && (q.size() > 0);
      drained = popped && hv;
      if (live) foreach (q[i]) if (q[i].rd == rd) q[i].v = 0;
      if (popped) void'(q.pop_front());
      if (mv && e_rdy && (mrd != 0) && !(live && mrd == rd)) q.push_back('{1'b1, mrd, md});
      if (drained || q.size() == 0) m_starve = 0;
      else if (live && hv && m_starve < LIMIT) m_starve++;
      m_stall = (q.size() > 0) && (m_starve == LIMIT || q.size() == DEPTH);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    @(posedge clk);
    #1;
    // reset with mc_valid held high: nothing may be enqueued
    cyc(0, 0, 0, 0, 1, 5, 32'h1234);
    cyc(0, 0, 0, 0, 1, 5, 32'h1234);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("idle_we", o_we, 0);
    chk("idle_rdy", o_rdy, 1);
    chk("idle_stall", o_stall, 0);

    // free-slot drain
    cyc(1, 0, 0, 0, 1, 5, 32'hDEADBEEF);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("drain_we", o_we, 1);
    chk("drain_a", o_a, 5);
    chk("drain_d", o_d, 32'hDEADBEEF);
    idle(1);
    chk("drain_empty_we", o_we, 0);

    // starvation
    cyc(1, 1, 7, 32'h77, 1, 3, 32'h33);
    for (int i = 0; i < 4; i++) cyc(1, 1, 7, 32'h77, 0, 0, 0);
    cyc(1, 1, 7, 32'h77, 0, 0, 0);
    chk("starve_stall", o_stall, 1);
    chk("starve_a", o_a, 3);
    cyc(1, 1, 7, 32'h77, 0, 0, 0);
    chk("starve_release", o_stall, 0);
    chk("starve_pipe_a", o_a, 7);
    idle(2);

    // full FIFO
    cyc(1, 1, 7, 32'h77, 1, 1, 32'h11);
    cyc(1, 1, 7, 32'h77, 1, 2, 32'h22);
    cyc(1, 1, 7, 32'h77, 0, 0, 0);
    chk("full_rdy", o_rdy, 0);
    chk("full_stall", o_stall, 1);
    chk("full_a", o_a, 1);
    for (int i = 0; i < 8; i++) cyc(1, 1, 7, 32'h77, 0, 0, 0);
    idle(2);

    // WAW kill
    cyc(1, 1, 7, 32'h77, 1, 9, 32'h11);
    cyc(1, 1, 9, 32'h22, 0, 0, 0);
    chk("waw_d", o_d, 32'h22);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("waw_dead_we", o_we, 0);
    chk("waw_stall", o_stall, 0);
    idle(2);

    // x0 handling
    cyc(1, 0, 0, 0, 1, 0, 32'h55);
    chk("x0_rdy", o_rdy, 1);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("x0_not_enq", o_we, 0);
    cyc(1, 1, 7, 32'h77, 1, 4, 32'h44);
    cyc(1, 1, 0, 32'h99, 0, 0, 0);
    chk("x0_pipe_drain_we", o_we, 1);
    chk("x0_pipe_drain_a", o_a, 4);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 99) != 0),
          ($urandom_range(0, 9) < 7),
          5'($urandom_range(0, 7)),
          $urandom(),
          ($urandom_range(0, 1) == 1),
          5'($urandom_range(0, 7)),
          $urandom());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
